// File: rtl/vme_bus_master.sv
// vme_bus_master
// Single-outstanding initiator for the on-chip VME-style register bus.
// A command taken on the cmd interface becomes a one-cycle read or write
// strobe. The master then waits for the matching Done pulse, or gives up
// after TIMEOUT cycles, and presents the result on the rsp interface.
//
// Handshake rule for both cmd and rsp: a transfer happens on a rising edge
// where valid and ready are both 1. The producer holds valid and payload
// stable until that edge. valid never depends on ready.
module vme_bus_master #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                    Clk,
    input  logic                    Rst,
    // command interface
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    // response interface
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    // bus side
    output logic [ADDR_WIDTH-1:1]   VMEAddr,
    output logic [DATA_WIDTH-1:0]   VMEWrData,
    output logic                    VMERdMem,
    output logic                    VMEWrMem,
    input  logic [DATA_WIDTH-1:0]   VMERdData,
    input  logic                    VMERdDone,
    input  logic                    VMEWrDone,
    // debug: current FSM state (0 IDLE, 1 STROBE, 2 WAIT, 3 RESP)
    output logic [1:0]              o_dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic                    r_write;
    logic [ADDR_WIDTH-1:1]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    logic                    w_accept;
    logic                    w_done;
    logic                    w_expire;
    logic                    w_unused_addr_lsb;

    // Byte-address bit 0 has no meaning on a 16-bit word bus.
    assign w_unused_addr_lsb = cmd_addr_i[0];

    // Only the Done that matches the issued strobe counts.
    assign w_done   = r_write ? VMEWrDone : VMERdDone;
    assign w_expire = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        VMERdMem    = 1'b0;
        VMEWrMem    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready_o = !Rst;
                if (cmd_valid_i && !Rst) begin
                    w_accept = 1'b1;
                    w_next   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                VMERdMem = !r_write;
                VMEWrMem = r_write;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done || w_expire) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Command capture, wait counter and response payload.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= cmd_write_i;
                r_addr  <= cmd_addr_i[ADDR_WIDTH-1:1];
                r_wdata <= cmd_wdata_i;
            end

            // Counter saturates at CNT_LAST; leaving WAIT happens there anyway.
            if (r_state == ST_STROBE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT && !w_done && !w_expire) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Payload is written once, on the WAIT exit, and then held
            // through RESP.
            if (r_state == ST_WAIT) begin
                if (w_done) begin
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_write ? '0 : VMERdData;
                end else if (w_expire) begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end
            end
        end
    end

    assign VMEAddr     = r_addr;
    assign VMEWrData   = r_wdata;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule
